// File: rtl/sm_step_gen.sv
// ---------------------------------------------------------------------------
// sm_step_gen
//
// Stepper-motor step-pulse generator. A move command (step count, step
// half-period, direction) is latched on an accepted start strobe; the block
// then drives the direction pin, waits a fixed setup delay, and emits exactly
// the requested number of evenly spaced step pulses. Timing can be paused
// with enable, a move can be cut short with abort, and every move ends with a
// one-cycle done pulse.
//
// Parameters:
//   CNT_W      width of the step count and steps_left
//   DIV_W      width of the half-period divider and internal timer
//   SETUP_CYC  cycles from drv_dir update to the first step rising edge (>=1)
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   start        command strobe, only honoured while idle
//   n_steps      number of step pulses for the move
//   half_period  cycles per high phase and per low phase (0 behaves as 1)
//   dir          direction for the move
//   enable       low pauses all move timing
//   abort        ends the current move early
//   drv_step     step pulse to the driver
//   drv_dir      direction to the driver
//   busy         a move is in progress (includes the done cycle)
//   done         one-cycle completion pulse
//   aborted      last move was ended by abort
//   steps_left   step pulses of the current move not yet completed
// ---------------------------------------------------------------------------
module sm_step_gen #(
   parameter int CNT_W     = 16,
   parameter int DIV_W     = 16,
   parameter int SETUP_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] n_steps,
   input  logic [DIV_W-1:0] half_period,
   input  logic             dir,
   input  logic             enable,
   input  logic             abort,
   output logic             drv_step,
   output logic             drv_dir,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] steps_left
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      DONE
   } state_t;

   // Terminal timer value for the direction setup phase.
   localparam logic [DIV_W-1:0] SETUP_LAST = DIV_W'(SETUP_CYC - 1);

   state_t           state;
   logic [DIV_W-1:0] timer;
   logic [DIV_W-1:0] half_cyc;
   logic [DIV_W-1:0] half_last;

   // half_cyc is never zero once a move is running, so this cannot wrap
   // while it is being used as a terminal count.
   assign half_last = half_cyc - DIV_W'(1);

   // Single FSM with all outputs registered. Every phase timer starts at 0
   // on phase entry and the phase ends on the edge where it reaches its
   // terminal value, so a phase of length L occupies exactly L cycles.
   // Abort is checked before enable so a paused move can still be aborted,
   // and it wins over a LOW-phase end so a truncated pulse is never counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         timer      <= '0;
         half_cyc   <= '0;
         steps_left <= '0;
         drv_step   <= 1'b0;
         drv_dir    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  steps_left <= n_steps;
                  half_cyc   <= (half_period == '0) ? DIV_W'(1) : half_period;
                  drv_dir    <= dir;
                  aborted    <= 1'b0;
                  timer      <= '0;
                  drv_step   <= 1'b0;
                  busy       <= 1'b1;
                  if (n_steps == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SETUP;
                  end
               end
            end

            SETUP, HIGH, LOW: begin
               if (abort) begin
                  state    <= DONE;
                  drv_step <= 1'b0;
                  done     <= 1'b1;
                  aborted  <= 1'b1;
                  timer    <= '0;
               end else if (enable) begin
                  case (state)
                     SETUP: begin
                        if (timer == SETUP_LAST) begin
                           timer    <= '0;
                           drv_step <= 1'b1;
                           state    <= HIGH;
                        end else begin
                           timer <= timer + DIV_W'(1);
                        end
                     end
                     HIGH: begin
                        if (timer == half_last) begin
                           timer    <= '0;
                           drv_step <= 1'b0;
                           state    <= LOW;
                        end else begin
                           timer <= timer + DIV_W'(1);
                        end
                     end
                     LOW: begin
                        if (timer == half_last) begin
                           timer <= '0;
                           if (steps_left != '0) begin
                              steps_left <= steps_left - CNT_W'(1);
                           end
                           // Last pulse finished when the count is about
                           // to reach zero.
                           if (steps_left <= CNT_W'(1)) begin
                              state <= DONE;
                              done  <= 1'b1;
                           end else begin
                              drv_step <= 1'b1;
                              state    <= HIGH;
                           end
                        end else begin
                           timer <= timer + DIV_W'(1);
                        end
                     end
                     default: begin
                     end
                  endcase
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               timer <= '0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sm_step_gen.md
# sm_step_gen

Parametrised stepper-motor step-pulse generator that replaces the fixed single-shot pulse counter in the SM drive path. It accepts a move command consisting of a step count, a step half-period and a direction. It then emits exactly that many evenly spaced step pulses on `drv_step`, with a direction setup delay before the first edge, pause-on-disable, abort, and a completion handshake. It sits between the motion-control logic, which issues commands synchronised to the ADC `data_valid_trig`, and the SM driver pins.

## Interface

Parameters:
- `CNT_W`, 16: width of step count and `steps_left`.
- `DIV_W`, 16: width of half-period divider.
- `SETUP_CYC`, 4: cycles between `drv_dir` update and first step rising edge; legal range ≥1.

Ports:
- `clk`  in  1  system clock, 50 MHz; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low; one clock domain only.
- `start`  in  1  command strobe, sampled in IDLE only.
- `n_steps`  in  CNT_W  number of step pulses, latched on accepted `start`.
- `half_period`  in  DIV_W  cycles per high phase and per low phase; 0 treated as 1; latched on accepted `start`.
- `dir`  in  1  direction, latched on accepted `start`.
- `enable`  in  1  SM enable; low pauses timing.
- `abort`  in  1  terminate current move.
- `drv_step`  out  1  step pulse to driver.
- `drv_dir`  out  1  direction to driver.
- `busy`  out  1  move in progress.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  last move ended by `abort`.
- `steps_left`  out  CNT_W  remaining step pulses not yet completed.

## Operation

- Reset (`rst_n`=0, any time, including mid-move): `drv_step`=0, `drv_dir`=0, `busy`=0, `done`=0, `aborted`=0, `steps_left`=0, state IDLE, timers 0.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE, `start`=1, `abort`=0:
  - Latch command: `steps_left`←`n_steps`, H←max(`half_period`,1), `drv_dir`←`dir`, `aborted`←0.
  - If `n_steps`=0, go to DONE. Otherwise go to SETUP with timer cleared.
- IDLE, `start`=1 with `abort`=1: command ignored, state stays IDLE.
- `start` outside IDLE: ignored; latched values unchanged.
- SETUP: `drv_step`=0. Timer counts to `SETUP_CYC`, then go to HIGH.
- HIGH: `drv_step`=1 for H cycles, then go to LOW.
- LOW: `drv_step`=0 for H cycles. At the end of LOW, `steps_left` decrements; if the new value is 0 go to DONE, else go to HIGH.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `drv_dir` holds its last value.
- `enable`=0 in SETUP, HIGH or LOW:
  - Timer and `steps_left` freeze; `drv_step` holds its level.
  - Resume on `enable`=1 with no lost or extra cycles.
  - `enable` has no effect in IDLE or DONE.
- `abort`=1 in SETUP, HIGH or LOW, regardless of `enable`:
  - Next state is DONE and `drv_step`=0.
  - `aborted`←1; it holds until the next accepted `start` or reset.
  - `steps_left` keeps the value at abort; a truncated pulse is not counted.
- `abort` in DONE: ignored.
- Widths: timer DIV_W bits, compared against H−1. `steps_left` never underflows. Maximum move is 2^CNT_W−1 steps.

## Timing

- Let E0 be the edge sampling an accepted `start` with `n_steps`=N>0.
  - Outputs after E0: `busy`=1, `drv_dir` valid, `drv_step`=0.
  - First `drv_step` rise is visible after edge E0+`SETUP_CYC`.
  - Each pulse is high H cycles and low H cycles, so the period is 2H.
  - `steps_left` decrements at each LOW end: E0+`SETUP_CYC`+2H·k for k=1..N.
  - `done`=1 during the cycle after edge E0+`SETUP_CYC`+2H·N; `busy` is still 1 in that cycle.
  - `busy`=0 from the following edge. Total busy = `SETUP_CYC`+2H·N+1 cycles.
- N=0: `busy`=1 and `done`=1 in the same cycle after E0; `drv_step` is never asserted.
- Abort sampled at edge Ea: `drv_step`=0 and `done`=1 after Ea; `busy`=0 after Ea+1.
- A new `start` is accepted at the earliest one cycle after `done`, i.e. the first IDLE cycle.
- Each cycle with `enable`=0 in SETUP, HIGH or LOW extends all later events by exactly one cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset/basic: release `rst_n`; start N=3, H=2, dir=1 → all outputs 0 after reset; `drv_dir`=1 after E0; rises at E0+4, E0+8, E0+12, each high 2 cycles; `steps_left` 3→2→1→0; `done` in the cycle after E0+16; `busy` 17 cycles.
- Edge values: N=0 → single `done` cycle, no step. `half_period`=0, N=2 → period 2 cycles (1 high, 1 low).
- Pause: N=2, H=3, `enable`=0 for 5 cycles starting mid-HIGH of pulse 1 → `drv_step` held 1 throughout; all later edges and `done` delayed exactly 5 cycles; no extra pulse.
- Abort: N=10, H=4, `abort` mid-HIGH of pulse 4 → `drv_step` drops next cycle; `done`=1 once; `aborted`=1; `steps_left`=7. Next `start` clears `aborted`.
- Command rules: `start` with changed `n_steps`/`dir` while busy → ignored, move unchanged. `start`+`abort` together in IDLE → no move. Assert `rst_n`=0 mid-HIGH → `drv_step`, `busy`, `steps_left` become 0 immediately, without waiting for `clk`.
